// File: rtl/dyn_branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB plus a PHT of saturating counters,
// indexed bimodally or gshare-style, with resolve-time training and statistics.
module dyn_branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2,
    parameter int MODE    = 0,
    localparam int IDX_W  = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      fetch_pc,
    output logic             pred_taken,
    output logic [15:0]      pred_target,
    output logic [IDX_W-1:0] pred_ghr,
    input  logic             stall,
    input  logic             resolve_valid,
    input  logic [15:0]      resolve_pc,
    input  logic             resolve_cond,
    input  logic             resolve_taken,
    input  logic [15:0]      resolve_target,
    input  logic             resolve_pred_taken,
    input  logic [15:0]      resolve_pred_target,
    input  logic [IDX_W-1:0] resolve_ghr,
    output logic             mispredict,
    output logic [15:0]      redirect_pc,
    output logic [15:0]      mispredict_count,
    output logic [15:0]      branch_count
);

    localparam int TAG_W = 15 - IDX_W;
    localparam logic [CTR_W-1:0] CTR_WEAK_T  = {1'b1, {(CTR_W-1){1'b0}}};
    localparam logic [CTR_W-1:0] CTR_WEAK_NT = {1'b0, {(CTR_W-1){1'b1}}};
    localparam logic [CTR_W-1:0] CTR_MAX     = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_ONE     = {{(CTR_W-1){1'b0}}, 1'b1};

    logic [ENTRIES-1:0]            btb_valid;
    logic [TAG_W-1:0]              btb_tag    [ENTRIES];
    logic [15:0]                   btb_target [ENTRIES];
    logic                          btb_uncond [ENTRIES];
    logic [ENTRIES-1:0][CTR_W-1:0] pht;
    logic [IDX_W-1:0]              ghr;

    logic [IDX_W-1:0] f_idx, f_pidx, r_idx, r_pidx;
    logic [TAG_W-1:0] f_tag, r_tag;
    logic             f_hit, r_hit, do_update;
    logic             unused_bits;

    assign unused_bits = fetch_pc[0] ^ resolve_pc[0] ^ resolve_ghr[IDX_W-1];

    assign f_idx  = fetch_pc[IDX_W:1];
    assign f_tag  = fetch_pc[15:IDX_W+1];
    assign f_pidx = (MODE == 1) ? (f_idx ^ ghr) : f_idx;
    assign f_hit  = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);

    assign pred_taken  = f_hit && (btb_uncond[f_idx] || pht[f_pidx][CTR_W-1]);
    assign pred_target = pred_taken ? btb_target[f_idx] : (fetch_pc + 16'd2);
    assign pred_ghr    = (MODE == 1) ? ghr : '0;

    // Training uses the GHR snapshot that travelled with the branch, not the live GHR.
    assign do_update = resolve_valid && !stall;
    assign r_idx     = resolve_pc[IDX_W:1];
    assign r_tag     = resolve_pc[15:IDX_W+1];
    assign r_pidx    = (MODE == 1) ? (r_idx ^ resolve_ghr) : r_idx;
    assign r_hit     = btb_valid[r_idx] && (btb_tag[r_idx] == r_tag);

    assign mispredict = do_update &&
                        ((resolve_taken != resolve_pred_taken) ||
                         (resolve_taken && (resolve_target != resolve_pred_target)));
    assign redirect_pc = resolve_taken ? resolve_target : (resolve_pc + 16'd2);

    // Payload storage is never reset; the valid bits alone decide whether it is used.
    always_ff @(posedge clk) begin
        if (rst_n && do_update && (!resolve_cond || resolve_taken)) begin
            btb_target[r_idx] <= resolve_target;
            if (!resolve_cond || !r_hit) begin
                btb_tag[r_idx]    <= r_tag;
                btb_uncond[r_idx] <= !resolve_cond;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btb_valid        <= '0;
            pht              <= {ENTRIES{CTR_WEAK_NT}};
            ghr              <= '0;
            branch_count     <= '0;
            mispredict_count <= '0;
        end else if (do_update) begin
            if (!resolve_cond) begin
                btb_valid[r_idx] <= 1'b1;
            end else begin
                ghr <= {resolve_ghr[IDX_W-2:0], resolve_taken};
                if (resolve_taken) begin
                    btb_valid[r_idx] <= 1'b1;
                    if (!r_hit)
                        pht[r_pidx] <= CTR_WEAK_T;
                    else if (pht[r_pidx] != CTR_MAX)
                        pht[r_pidx] <= pht[r_pidx] + CTR_ONE;
                end else if (r_hit && (pht[r_pidx] != '0)) begin
                    pht[r_pidx] <= pht[r_pidx] - CTR_ONE;
                end
            end
            if (branch_count != 16'hFFFF)
                branch_count <= branch_count + 16'd1;
            if (mispredict && (mispredict_count != 16'hFFFF))
                mispredict_count <= mispredict_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_dyn_branch_predictor.sv
// Scoreboard bench for dyn_branch_predictor: a bimodal 16-entry instance and a
// gshare 4-entry instance share stimulus; expectations are queued and checked by a monitor.
module tb_dyn_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] fetch_pc;
    logic        stall, resolve_valid, resolve_cond, resolve_taken, resolve_pred_taken;
    logic [15:0] resolve_pc, resolve_target, resolve_pred_target;
    logic [3:0]  resolve_ghr;
    logic [1:0]  resolve_ghr_g;

    logic        pred_taken, mispredict, pred_taken_g, mispredict_g;
    logic [15:0] pred_target, redirect_pc, mispredict_count, branch_count;
    logic [15:0] pred_target_g, redirect_pc_g, mispredict_count_g, branch_count_g;
    logic [3:0]  pred_ghr;
    logic [1:0]  pred_ghr_g;

    dyn_branch_predictor dut (
        .clk(clk), .rst_n(rst_n), .fetch_pc(fetch_pc),
        .pred_taken(pred_taken), .pred_target(pred_target), .pred_ghr(pred_ghr),
        .stall(stall), .resolve_valid(resolve_valid), .resolve_pc(resolve_pc),
        .resolve_cond(resolve_cond), .resolve_taken(resolve_taken),
        .resolve_target(resolve_target), .resolve_pred_taken(resolve_pred_taken),
        .resolve_pred_target(resolve_pred_target), .resolve_ghr(resolve_ghr),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .mispredict_count(mispredict_count), .branch_count(branch_count)
    );

    dyn_branch_predictor #(.ENTRIES(4), .CTR_W(2), .MODE(1)) dut_g (
        .clk(clk), .rst_n(rst_n), .fetch_pc(fetch_pc),
        .pred_taken(pred_taken_g), .pred_target(pred_target_g), .pred_ghr(pred_ghr_g),
        .stall(stall), .resolve_valid(resolve_valid), .resolve_pc(resolve_pc),
        .resolve_cond(resolve_cond), .resolve_taken(resolve_taken),
        .resolve_target(resolve_target), .resolve_pred_taken(resolve_pred_taken),
        .resolve_pred_target(resolve_pred_target), .resolve_ghr(resolve_ghr_g),
        .mispredict(mispredict_g), .redirect_pc(redirect_pc_g),
        .mispredict_count(mispredict_count_g), .branch_count(branch_count_g)
    );

    always #5 clk = ~clk;

    typedef enum {S_PT, S_PTGT, S_PGHR, S_MIS, S_RDR, S_MCNT, S_BCNT, S_GPT, S_GPTGT, S_GGHR} sel_e;
    typedef struct {
        string       name;
        sel_e        sel;
        logic [15:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;
    event probe;

    function automatic logic [15:0] observe(sel_e s);
        logic [15:0] v;
        v = '0;
        case (s)
            S_PT:    v = {15'd0, pred_taken};
            S_PTGT:  v = pred_target;
            S_PGHR:  v = {12'd0, pred_ghr};
            S_MIS:   v = {15'd0, mispredict};
            S_RDR:   v = redirect_pc;
            S_MCNT:  v = mispredict_count;
            S_BCNT:  v = branch_count;
            S_GPT:   v = {15'd0, pred_taken_g};
            S_GPTGT: v = pred_target_g;
            S_GGHR:  v = {14'd0, pred_ghr_g};
            default: v = '0;
        endcase
        return v;
    endfunction

    task automatic checkOutput(input exp_t e);
        logic [15:0] act;
        act = observe(e.sel);
        checks++;
        if (act === e.exp)
            passed++;
        else
            $display("[TB] FAIL %s: got %h, expected %h", e.name, act, e.exp);
    endtask

    // Monitor: whenever the stimulus side announces a sample point, drain the queue.
    initial begin
        exp_t e;
        forever begin
            @(probe);
            #1;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput(e);
            end
        end
    end

    task automatic expectVal(input string name, input sel_e sel, input logic [15:0] exp);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic sample();
        -> probe;
    endtask

    task automatic applyStimulus(input logic [15:0] fpc, input logic rv, input logic cond,
                                 input logic taken, input logic [15:0] rpc,
                                 input logic [15:0] tgt, input logic ppt,
                                 input logic [15:0] pptgt, input logic stl);
        @(negedge clk);
        fetch_pc            = fpc;
        resolve_valid       = rv;
        resolve_cond        = cond;
        resolve_taken       = taken;
        resolve_pc          = rpc;
        resolve_target      = tgt;
        resolve_pred_taken  = ppt;
        resolve_pred_target = pptgt;
        stall               = stl;
    endtask

    task automatic idle(input logic [15:0] fpc);
        applyStimulus(fpc, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0; fetch_pc = '0; stall = 1'b0; resolve_valid = 1'b0;
        resolve_cond = 1'b0; resolve_taken = 1'b0; resolve_pc = '0; resolve_target = '0;
        resolve_pred_taken = 1'b0; resolve_pred_target = '0; resolve_ghr = '0; resolve_ghr_g = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        idle(16'h0040);
        expectVal("reset_pred_taken", S_PT, 16'd0);
        expectVal("reset_pred_target", S_PTGT, 16'h0042);
        expectVal("reset_pred_ghr", S_PGHR, 16'd0);
        expectVal("reset_mispredict", S_MIS, 16'd0);
        expectVal("reset_mcount", S_MCNT, 16'd0);
        expectVal("reset_bcount", S_BCNT, 16'd0);
        sample();

        // First taken resolve at 0x0040 allocates; lookup in the same cycle sees old contents.
        applyStimulus(16'h0040, 1, 1, 1, 16'h0040, 16'h0100, 0, 16'h0042, 0);
        expectVal("alloc_mispredict", S_MIS, 16'd1);
        expectVal("alloc_redirect", S_RDR, 16'h0100);
        expectVal("alloc_no_bypass", S_PT, 16'd0);
        sample();

        idle(16'h0040);
        expectVal("after_alloc_pt", S_PT, 16'd1);
        expectVal("after_alloc_target", S_PTGT, 16'h0100);
        expectVal("after_alloc_bcount", S_BCNT, 16'd1);
        expectVal("after_alloc_mcount", S_MCNT, 16'd1);
        sample();

        // Six not-taken resolves: counter 2 -> 1 -> 0 and stays at 0.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(16'h0040, 1, 1, 0, 16'h0040, 16'h0100, (i == 0),
                          (i == 0) ? 16'h0100 : 16'h0042, 0);
            expectVal($sformatf("nt%0d_pt", i), S_PT, (i == 0) ? 16'd1 : 16'd0);
            expectVal($sformatf("nt%0d_mispredict", i), S_MIS, (i == 0) ? 16'd1 : 16'd0);
            if (i == 0) expectVal("nt0_redirect", S_RDR, 16'h0042);
            sample();
        end
        idle(16'h0040);
        expectVal("sat0_pt", S_PT, 16'd0);
        expectVal("sat0_target", S_PTGT, 16'h0042);
        expectVal("sat0_bcount", S_BCNT, 16'd7);
        expectVal("sat0_mcount", S_MCNT, 16'd2);
        sample();

        // Stalled resolves must leave all state alone.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(16'h0040, 1, 1, 1, 16'h0040, 16'h0100, 0, 16'h0042, 1);
            expectVal($sformatf("stall%0d_mispredict", i), S_MIS, 16'd0);
            expectVal($sformatf("stall%0d_bcount", i), S_BCNT, 16'd7);
            expectVal($sformatf("stall%0d_mcount", i), S_MCNT, 16'd2);
            expectVal($sformatf("stall%0d_pt", i), S_PT, 16'd0);
            sample();
        end
        applyStimulus(16'h0040, 1, 1, 1, 16'h0040, 16'h0100, 0, 16'h0042, 0);
        expectVal("unstall_mispredict", S_MIS, 16'd1);
        expectVal("unstall_redirect", S_RDR, 16'h0100);
        sample();
        idle(16'h0040);
        expectVal("one_update_pt", S_PT, 16'd0);
        expectVal("one_update_bcount", S_BCNT, 16'd8);
        expectVal("one_update_mcount", S_MCNT, 16'd3);
        sample();
        applyStimulus(16'h0040, 1, 1, 1, 16'h0040, 16'h0100, 0, 16'h0042, 0);
        expectVal("inc_mispredict", S_MIS, 16'd1);
        sample();
        idle(16'h0040);
        expectVal("inc_pt", S_PT, 16'd1);
        expectVal("inc_target", S_PTGT, 16'h0100);
        sample();

        // Unconditional jumps: allocation, correct prediction, wrong target.
        applyStimulus(16'h0208, 1, 0, 1, 16'h0208, 16'h0300, 0, 16'h020A, 0);
        expectVal("jmp_alloc_mispredict", S_MIS, 16'd1);
        expectVal("jmp_alloc_redirect", S_RDR, 16'h0300);
        sample();
        applyStimulus(16'h0208, 1, 0, 1, 16'h0208, 16'h0300, 1, 16'h0300, 0);
        expectVal("jmp_hit_pt", S_PT, 16'd1);
        expectVal("jmp_hit_target", S_PTGT, 16'h0300);
        expectVal("jmp_hit_mispredict", S_MIS, 16'd0);
        sample();
        applyStimulus(16'h0208, 1, 0, 1, 16'h0208, 16'h0310, 1, 16'h0300, 0);
        expectVal("jmp_tgt_mispredict", S_MIS, 16'd1);
        expectVal("jmp_tgt_redirect", S_RDR, 16'h0310);
        sample();
        idle(16'h0208);
        expectVal("jmp_refresh_pt", S_PT, 16'd1);
        expectVal("jmp_refresh_target", S_PTGT, 16'h0310);
        expectVal("jmp_bcount", S_BCNT, 16'd12);
        expectVal("jmp_mcount", S_MCNT, 16'd6);
        sample();

        // Not-taken miss aliasing index 0 must not disturb the 0x0040 entry.
        applyStimulus(16'h0040, 1, 1, 0, 16'h0400, 16'h0500, 0, 16'h0402, 0);
        expectVal("ntmiss_mispredict", S_MIS, 16'd0);
        expectVal("ntmiss_redirect", S_RDR, 16'h0402);
        sample();
        idle(16'h0040);
        expectVal("ntmiss_keep_pt", S_PT, 16'd1);
        expectVal("ntmiss_keep_target", S_PTGT, 16'h0100);
        expectVal("ntmiss_bcount", S_BCNT, 16'd13);
        sample();
        idle(16'h0400);
        expectVal("ntmiss_no_alloc_pt", S_PT, 16'd0);
        expectVal("ntmiss_no_alloc_target", S_PTGT, 16'h0402);
        sample();

        // Statistic saturation.
        @(negedge clk);
        force dut.branch_count = 16'hFFFE;
        #1;
        release dut.branch_count;
        expectVal("forced_bcount", S_BCNT, 16'hFFFE);
        sample();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(16'h0400, 1, 1, 0, 16'h0400, 16'h0500, 0, 16'h0402, 0);
            expectVal($sformatf("satcnt%0d_bcount", i), S_BCNT, (i == 0) ? 16'hFFFE : 16'hFFFF);
            sample();
        end
        idle(16'h0400);
        expectVal("satcnt_final_bcount", S_BCNT, 16'hFFFF);
        expectVal("satcnt_final_mcount", S_MCNT, 16'd6);
        sample();

        // Asynchronous reset mid-cycle, an update lost under reset, then a normal first edge.
        applyStimulus(16'h0040, 1, 0, 1, 16'h0040, 16'h0100, 0, 16'h0042, 0);
        #2;
        rst_n = 1'b0;
        expectVal("async_rst_bcount", S_BCNT, 16'd0);
        expectVal("async_rst_mcount", S_MCNT, 16'd0);
        expectVal("async_rst_pt", S_PT, 16'd0);
        expectVal("async_rst_target", S_PTGT, 16'h0042);
        sample();
        applyStimulus(16'h0040, 1, 0, 1, 16'h0040, 16'h0100, 0, 16'h0042, 0);
        expectVal("lost_update_bcount", S_BCNT, 16'd0);
        expectVal("lost_update_pt", S_PT, 16'd0);
        sample();
        applyStimulus(16'h0040, 1, 0, 1, 16'h0040, 16'h0100, 0, 16'h0042, 0);
        rst_n = 1'b1;
        expectVal("first_edge_mispredict", S_MIS, 16'd1);
        sample();
        idle(16'h0040);
        expectVal("first_edge_bcount", S_BCNT, 16'd1);
        expectVal("first_edge_pt", S_PT, 16'd1);
        expectVal("first_edge_target", S_PTGT, 16'h0100);
        expectVal("g_jmp_pt", S_GPT, 16'd1);
        expectVal("g_jmp_target", S_GPTGT, 16'h0100);
        expectVal("g_ghr0", S_GGHR, 16'd0);
        sample();

        // Gshare: allocation at pht[1^0], lookup afterwards at pht[1^1] which is still weak-NT.
        resolve_ghr_g = 2'd0;
        applyStimulus(16'h0052, 1, 1, 1, 16'h0052, 16'h0700, 0, 16'h0054, 0);
        expectVal("g_cond_mispredict", S_MIS, 16'd1);
        sample();
        idle(16'h0052);
        expectVal("g_cond_ghr", S_GGHR, 16'd1);
        expectVal("g_cond_pt", S_GPT, 16'd0);
        expectVal("g_cond_target", S_GPTGT, 16'h0054);
        expectVal("bimodal_cond_pt", S_PT, 16'd1);
        expectVal("bimodal_cond_target", S_PTGT, 16'h0700);
        expectVal("bimodal_ghr", S_PGHR, 16'd0);
        sample();

        // 0x0048 aliases 0x0040 in the 4-entry table with a different tag.
        resolve_ghr_g = 2'd1;
        applyStimulus(16'h0048, 1, 0, 1, 16'h0048, 16'h0600, 0, 16'h004A, 0);
        expectVal("evict_mispredict", S_MIS, 16'd1);
        sample();
        idle(16'h0040);
        expectVal("evicted_g_pt", S_GPT, 16'd0);
        expectVal("evicted_g_target", S_GPTGT, 16'h0042);
        expectVal("evicted_g_ghr", S_GGHR, 16'd1);
        expectVal("bimodal_kept_pt", S_PT, 16'd1);
        expectVal("bimodal_kept_bcount", S_BCNT, 16'd3);
        sample();
        idle(16'h0048);
        expectVal("evictor_g_pt", S_GPT, 16'd1);
        expectVal("evictor_g_target", S_GPTGT, 16'h0600);
        sample();

        @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/dyn_branch_predictor.md
DYN_BRANCH_PREDICTOR -- requirements
Module: dyn_branch_predictor

Interface
REQ-001 Parameter ENTRIES, default 16, means BTB and PHT depth; it SHALL be a power of 2 from 4 to 256, with IDX_W = log2(ENTRIES).
REQ-002 Parameter CTR_W, default 2, means the saturating counter width; legal range is 2 to 4.
REQ-003 Parameter MODE, default 0, means PHT indexing: 0 = bimodal, 1 = gshare.
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port fetch_pc, input, 16 bits: the fetch address being looked up.
REQ-007 Port pred_taken, output, 1 bit: predict redirect.
REQ-008 Port pred_target, output, 16 bits: next fetch PC.
REQ-009 Port pred_ghr, output, IDX_W bits: GHR snapshot to carry down the pipe.
REQ-010 Port stall, input, 1 bit: pipeline stall; it suppresses all updates.
REQ-011 Port resolve_valid, input, 1 bit: a branch, jump, JSR or TRAP resolved in MEM.
REQ-012 Port resolve_pc, input, 16 bits: PC of the resolving instruction.
REQ-013 Port resolve_cond, input, 1 bit: 1 = conditional BR, 0 = unconditional.
REQ-014 Port resolve_taken, input, 1 bit: the actual outcome.
REQ-015 Port resolve_target, input, 16 bits: the actual target.
REQ-016 Port resolve_pred_taken, input, 1 bit: the prediction carried down the pipe.
REQ-017 Port resolve_pred_target, input, 16 bits: the predicted target carried down the pipe.
REQ-018 Port resolve_ghr, input, IDX_W bits: the GHR snapshot carried down the pipe.
REQ-019 Port mispredict, output, 1 bit: flush the younger stages.
REQ-020 Port redirect_pc, output, 16 bits: the corrected PC.
REQ-021 Port mispredict_count, output, 16 bits: statistic.
REQ-022 Port branch_count, output, 16 bits: statistic.

Function
REQ-023 The BTB SHALL be indexed by pc[IDX_W:1]; each entry SHALL hold valid, tag = pc[15:IDX_W+1], target[15:0] and an uncond bit.
REQ-024 The PHT SHALL hold ENTRIES counters of CTR_W bits each; its index SHALL be pc[IDX_W:1] when MODE=0 and pc[IDX_W:1] XOR GHR when MODE=1.
REQ-025 Lookup SHALL be combinational (0-cycle latency): hit = valid and tag match.
REQ-026 pred_taken SHALL equal hit AND (uncond OR counter MSB).
REQ-027 pred_target SHALL be the BTB target when pred_taken, else fetch_pc+2 (mod 2^16).
REQ-028 pred_ghr SHALL equal the current GHR; it SHALL be 0 when MODE=0.
REQ-029 An update SHALL occur only on a rising clk edge where resolve_valid=1 and stall=0; otherwise all tables, the GHR and the counters SHALL hold.
REQ-030 When MODE=1, the update-time PHT index SHALL use resolve_ghr, not the live GHR.
REQ-031 Conditional taken, BTB miss: allocate the BTB entry (overwriting unconditionally), set uncond=0, and set the counter to weakly-taken = 2^(CTR_W-1).
REQ-032 Conditional taken, BTB hit: increment the counter, saturating at 2^CTR_W-1, and rewrite the target.
REQ-033 Conditional not-taken, BTB hit: decrement the counter, saturating at 0.
REQ-034 Conditional not-taken, BTB miss: no table change.
REQ-035 Unconditional: allocate or refresh the BTB entry with uncond=1 and target=resolve_target; the PHT SHALL be untouched.
REQ-036 The GHR SHALL update on conditional resolves only, as GHR <= {resolve_ghr[IDX_W-2:0], resolve_taken}, which repairs speculative divergence.
REQ-037 mispredict SHALL be combinational: resolve_valid and not stall and (resolve_taken != resolve_pred_taken, or resolve_taken and resolve_target != resolve_pred_target).
REQ-038 redirect_pc SHALL be resolve_target when resolve_taken, else resolve_pc+2; when mispredict=0 its value is don't-care.
REQ-039 When a fetch and an update target the same index in the same cycle, the lookup SHALL return the pre-update contents (no bypass).
REQ-040 branch_count SHALL increment on each update; mispredict_count SHALL increment on each update with mispredict=1; both SHALL saturate at 16'hFFFF without wrapping.

Reset
REQ-041 When rst_n=0, all BTB valid bits SHALL be 0, all counters SHALL be weakly-not-taken = 2^(CTR_W-1)-1, GHR=0 and both statistics counters = 0, immediately and regardless of clk.
REQ-042 Target, tag and uncond storage need not be reset.
REQ-043 An update coinciding with reset assertion SHALL be lost.
REQ-044 The first rising edge after deassertion SHALL perform a normal update.

Verification
REQ-045 Reset, then fetch_pc=16'h0040: pred_taken=0, pred_target=16'h0042, mispredict_count=0.
REQ-046 Resolve cond taken at pc=16'h0040, target=16'h0100, pred_taken=0: mispredict=1 and redirect_pc=16'h0100; next cycle, fetch 16'h0040 gives pred_taken=1 and pred_target=16'h0100.
REQ-047 Five not-taken resolves at 16'h0040 with CTR_W=2: the counter saturates at 0, pred_taken=0, and a sixth not-taken resolve with pred_taken=0 gives mispredict=0.
REQ-048 resolve_valid=1 with stall=1 for 3 cycles: no table, GHR or statistic change, mispredict=0; stall falls and exactly one update occurs.
REQ-049 MODE=1, ENTRIES=4: two PCs aliasing in BTB index with different tags cause the second allocation to evict the first; the first then misses (pred_target = pc+2).
REQ-050 Force branch_count to 16'hFFFE, then apply 3 updates: the count holds at 16'hFFFF; pulsing rst_n low mid-stream clears it to 0 asynchronously.
